// File: rtl/s_term_sram_loopback_bist_if.sv
// Loopback wire bundle between the south-terminal BIST and the routing fabric.
//   tx_n1/tx_n2/tx_n4 : northbound single/double/quad begin wires (N1BEG/N2BEG/N4BEG)
//   rx_s1/rx_s2/rx_s2b/rx_s4 : southbound returns (S1END/S2MID/S2END/S4END)
//   master : the BIST side (drives tx, observes rx)
//   slave  : the fabric/loopback side (observes tx, drives rx)
interface s_term_sram_loopback_bist_if;
   logic [3:0]  tx_n1;
   logic [7:0]  tx_n2;
   logic [15:0] tx_n4;
   logic [3:0]  rx_s1;
   logic [7:0]  rx_s2;
   logic [7:0]  rx_s2b;
   logic [15:0] rx_s4;

   modport master (
      output tx_n1, tx_n2, tx_n4,
      input  rx_s1, rx_s2, rx_s2b, rx_s4
   );

   modport slave (
      input  tx_n1, tx_n2, tx_n4,
      output rx_s1, rx_s2, rx_s2b, rx_s4
   );
endinterface

// File: rtl/s_term_sram_loopback_bist.sv
// North/south routing loopback self-test for an SRAM tile column.
// Drives walking-one then LFSR patterns northbound, expects each wire group
// back bit-reversed on the southbound wires, and accumulates results.
//   UserCLK   : fabric user clock, rising edge
//   Reset     : synchronous, active-high
//   start     : level, honoured only in IDLE and DONE
//   lb        : loopback wire bundle (master side)
//   busy      : run in progress
//   done      : run finished, results valid
//   pass      : done with no mismatching pattern
//   err_count : failing patterns, saturating at 255
//   fail_mask : sticky OR of per-bit mismatches {rx_s4, rx_s2b, rx_s2, rx_s1}
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | tx held at zero, waiting for start
// S_DRIVE | current pattern on tx, settle timer counting down
// S_CHECK | compare rx against reversed pattern, advance or finish
// S_DONE  | tx zero, results held until the next start
module s_term_sram_loopback_bist #(
   parameter int unsigned SETTLE   = 4,
   parameter int unsigned NUM_RAND = 64,
   parameter logic [27:0] SEED     = 28'h0000001
) (
   input  logic                        UserCLK,
   input  logic                        Reset,
   input  logic                        start,
   s_term_sram_loopback_bist_if.master lb,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [7:0]                  err_count,
   output logic [35:0]                 fail_mask
);
   localparam int unsigned TOTAL        = 28 + NUM_RAND;
   localparam int          CW           = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int          IW           = $clog2(TOTAL);
   localparam logic [27:0] SEED_EFF     = (SEED == 28'd0) ? 28'h0000001 : SEED;
   localparam logic [CW-1:0] CNT_LOAD   = CW'(SETTLE - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(TOTAL - 1);
   localparam logic [IW-1:0] IDX_WALK_END = IW'(27);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

   state_t          state, state_nxt;
   logic            load_run, check_en, last;
   logic [CW-1:0]   settle_cnt;
   logic [IW-1:0]   pat_idx;
   logic [27:0]     pat, lfsr, lfsr_step, tx_word;
   logic [35:0]     exp_vec, mis;
   logic [7:0]      err_nxt;

   assign last      = (pat_idx == IDX_LAST);
   assign lfsr_step = {lfsr[26:0], lfsr[27] ^ lfsr[24]};
   assign tx_word   = ((state == S_DRIVE) || (state == S_CHECK)) ? pat : 28'd0;

   assign lb.tx_n1 = tx_word[3:0];
   assign lb.tx_n2 = tx_word[11:4];
   assign lb.tx_n4 = tx_word[27:12];

   // Expected return is each wire group reversed; rx_s2 and rx_s2b both carry the double group.
   always_comb begin
      exp_vec = '0;
      for (int i = 0; i < 4; i++)  exp_vec[i] = pat[3-i];
      for (int i = 0; i < 8; i++) begin
         exp_vec[4+i]  = pat[11-i];
         exp_vec[12+i] = pat[11-i];
      end
      for (int i = 0; i < 16; i++) exp_vec[20+i] = pat[27-i];
   end

   assign mis = {lb.rx_s4, lb.rx_s2b, lb.rx_s2, lb.rx_s1} ^ exp_vec;

   always_comb begin
      err_nxt = err_count;
      if (check_en && (mis != 36'd0) && (err_count != 8'hFF))
         err_nxt = err_count + 8'd1;
   end

   always_ff @(posedge UserCLK) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_run  = 1'b0;
      check_en  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               load_run  = 1'b1;
               state_nxt = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (settle_cnt == '0) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            check_en  = 1'b1;
            state_nxt = last ? S_DONE : S_DRIVE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge UserCLK) begin
      if (Reset) begin
         settle_cnt <= '0;
         pat_idx    <= '0;
         pat        <= '0;
         lfsr       <= SEED_EFF;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_mask  <= '0;
      end else begin
         busy <= (state_nxt == S_DRIVE) || (state_nxt == S_CHECK);
         done <= (state_nxt == S_DONE);
         pass <= (state_nxt == S_DONE) && (err_nxt == 8'd0);
         if ((state == S_DRIVE) && (settle_cnt != '0))
            settle_cnt <= settle_cnt - 1'b1;
         if (load_run) begin
            settle_cnt <= CNT_LOAD;
            pat_idx    <= '0;
            pat        <= 28'h0000001;
            lfsr       <= SEED_EFF;
            err_count  <= '0;
            fail_mask  <= '0;
         end
         if (check_en) begin
            err_count <= err_nxt;
            fail_mask <= fail_mask | mis;
            if (!last) begin
               settle_cnt <= CNT_LOAD;
               pat_idx    <= pat_idx + 1'b1;
               // lfsr holds the current random pattern; the seed itself is the first one.
               if (pat_idx < IDX_WALK_END) begin
                  pat <= pat << 1;
               end else if (pat_idx == IDX_WALK_END) begin
                  pat <= lfsr;
               end else begin
                  pat  <= lfsr_step;
                  lfsr <= lfsr_step;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_s_term_sram_loopback_bist.sv
module tb_s_term_sram_loopback_bist;
   localparam int S    = 4;
   localparam int NR   = 64;
   localparam int NPAT = 28 + NR;
   localparam int RUN  = NPAT * (S + 1);
   localparam logic [27:0] SEED_A = 28'h0000001;
   localparam int S_B  = 1;
   localparam int NR_B = 300;

   typedef struct packed {
      logic [7:0]  err;
      logic [35:0] mask;
      logic        pass;
   } result_t;

   logic UserCLK = 1'b0;
   logic Reset   = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
   logic [7:0]  err_a, err_b;
   logic [35:0] mask_a, mask_b;

   int checks = 0;
   int errors = 0;
   int mode = 0;
   int dly  = 0;
   logic [27:0] pat_q[$];
   result_t     res_q[$];

   always #5 UserCLK = ~UserCLK;

   s_term_sram_loopback_bist_if lb_a ();
   s_term_sram_loopback_bist_if lb_b ();

   s_term_sram_loopback_bist #(.SETTLE(S), .NUM_RAND(NR), .SEED(SEED_A)) dut_a (
      .UserCLK(UserCLK), .Reset(Reset), .start(start_a), .lb(lb_a.master),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_mask(mask_a)
   );

   s_term_sram_loopback_bist #(.SETTLE(S_B), .NUM_RAND(NR_B), .SEED(28'h0000000)) dut_b (
      .UserCLK(UserCLK), .Reset(Reset), .start(start_b), .lb(lb_b.master),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_mask(mask_b)
   );

   function automatic logic [15:0] rev(input logic [15:0] x, input int n);
      logic [15:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = x[n-1-i];
      return r;
   endfunction

   function automatic logic [35:0] ideal_rx(input logic [27:0] p);
      logic [15:0] r1, r2, r4;
      r1 = rev({12'b0, p[3:0]}, 4);
      r2 = rev({8'b0, p[11:4]}, 8);
      r4 = rev(p[27:12], 16);
      return {r4, r2[7:0], r2[7:0], r1[3:0]};
   endfunction

   // mode 0 ideal, 1 rx_s4[3] stuck at 0, 2 rx_s1 unreversed
   function automatic logic [35:0] fwd(input logic [27:0] p, input int m);
      logic [35:0] r;
      r = ideal_rx(p);
      if (m == 1) r[23] = 1'b0;
      if (m == 2) r[3:0] = p[3:0];
      return r;
   endfunction

   function automatic logic [35:0] model_mis(input logic [27:0] p, input int m);
      case (m)
         1:       return p[24] ? 36'h000800000 : 36'h0;
         2:       return {32'b0, p[3:0] ^ {p[0], p[1], p[2], p[3]}};
         default: return 36'h0;
      endcase
   endfunction

   function automatic logic [27:0] lfsr_next(input logic [27:0] l);
      return {l[26:0], l[27] ^ l[24]};
   endfunction

   // Loopback A: selectable fault plus 0..6 cycle path delay
   logic [27:0] tx_word_a;
   logic [35:0] line_a [0:5];
   logic [35:0] rx_a;
   assign tx_word_a = {lb_a.tx_n4, lb_a.tx_n2, lb_a.tx_n1};

   always @(posedge UserCLK) begin
      line_a[0] <= fwd(tx_word_a, mode);
      for (int i = 1; i < 6; i++) line_a[i] <= line_a[i-1];
   end

   always_comb rx_a = (dly == 0) ? fwd(tx_word_a, mode) : line_a[dly-1];

   assign lb_a.rx_s1  = rx_a[3:0];
   assign lb_a.rx_s2  = rx_a[11:4];
   assign lb_a.rx_s2b = rx_a[19:12];
   assign lb_a.rx_s4  = rx_a[35:20];

   // Loopback B: every returned bit inverted
   logic [35:0] rx_b;
   assign rx_b = ~ideal_rx({lb_b.tx_n4, lb_b.tx_n2, lb_b.tx_n1});
   assign lb_b.rx_s1  = rx_b[3:0];
   assign lb_b.rx_s2  = rx_b[11:4];
   assign lb_b.rx_s2b = rx_b[19:12];
   assign lb_b.rx_s4  = rx_b[35:20];

   task automatic push_run_a(input int m);
      logic [27:0] p, l;
      logic [35:0] mm, mask;
      int          cnt;
      result_t     r;
      l = SEED_A; mask = '0; cnt = 0;
      for (int k = 0; k < NPAT; k++) begin
         if (k < 28) p = 28'h1 << k;
         else begin
            p = l;
            l = lfsr_next(l);
         end
         pat_q.push_back(p);
         mm = model_mis(p, m);
         if (mm != 36'h0 && cnt < 255) cnt++;
         mask |= mm;
      end
      r.err = 8'(cnt); r.mask = mask; r.pass = (cnt == 0);
      res_q.push_back(r);
   endtask

   task automatic run_a(input int m, input int d, input int pulse_at, input bit exact, input string name);
      logic [27:0] exp_p, got_p;
      result_t     exp_r;
      int          busy_cnt, first_done;
      mode = m; dly = d;
      push_run_a(m);
      @(negedge UserCLK); start_a = 1'b1;
      @(posedge UserCLK); #1 start_a = 1'b0;
      busy_cnt = 0; first_done = 0;
      for (int c = 1; c <= RUN + 5; c++) begin
         @(negedge UserCLK);
         start_a = (c == pulse_at);
         if (busy_a) busy_cnt++;
         if (done_a && first_done == 0) first_done = c;
         if (c <= RUN && ((c - 1) % (S + 1)) == 0) begin
            got_p = {lb_a.tx_n4, lb_a.tx_n2, lb_a.tx_n1};
            checks++;
            if (pat_q.size() == 0) begin
               errors++;
               $display("FAIL %s pattern_queue_empty at cycle %0d", name, c);
            end else begin
               exp_p = pat_q.pop_front();
               if (got_p !== exp_p) begin
                  errors++;
                  $display("FAIL %s pattern cycle %0d: tx=%h expected %h", name, c, got_p, exp_p);
               end
            end
         end
         if (c == RUN + 1) begin
            exp_r = res_q.pop_front();
            checks++;
            if (tx_word_a !== 28'h0) begin
               errors++;
               $display("FAIL %s tx_in_done: got %h expected 0", name, tx_word_a);
            end
            if (exact) begin
               checks++;
               if (err_a !== exp_r.err) begin
                  errors++;
                  $display("FAIL %s err_count: got %0d expected %0d", name, err_a, exp_r.err);
               end
               checks++;
               if (mask_a !== exp_r.mask) begin
                  errors++;
                  $display("FAIL %s fail_mask: got %h expected %h", name, mask_a, exp_r.mask);
               end
               checks++;
               if (pass_a !== exp_r.pass) begin
                  errors++;
                  $display("FAIL %s pass: got %b expected %b", name, pass_a, exp_r.pass);
               end
            end else begin
               checks++;
               if (!(err_a > 8'd0) || pass_a !== 1'b0) begin
                  errors++;
                  $display("FAIL %s late_loopback: err_count=%0d pass=%b expected err>0 pass=0", name, err_a, pass_a);
               end
            end
         end
      end
      checks++;
      if (busy_cnt != RUN) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, RUN);
      end
      checks++;
      if (first_done != RUN + 1) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d expected %0d", name, first_done, RUN + 1);
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [86:0] got;
      got = {busy_a, done_a, pass_a, err_a, mask_a, tx_word_a, busy_b, done_b, pass_b, err_b};
      checks++;
      if (got !== 87'h0) begin
         errors++;
         $display("FAIL %s outputs: got %h expected 0", name, got);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (8) @(posedge UserCLK);
      @(negedge UserCLK);
      check_all_zero("reset");
      checks++;
      if (mask_b !== 36'h0) begin
         errors++;
         $display("FAIL reset mask_b: got %h expected 0", mask_b);
      end
      Reset = 1'b0;
      repeat (2) @(negedge UserCLK);
   endtask

   task automatic test_ideal();
      run_a(0, 0, 0, 1'b1, "ideal");
   endtask

   task automatic test_start_ignored();
      run_a(0, 0, 100, 1'b1, "start_ignored");
   endtask

   task automatic test_stuck_s4();
      run_a(1, 0, 0, 1'b1, "stuck_s4_3");
   endtask

   task automatic test_unreversed_s1();
      run_a(2, 0, 0, 1'b1, "unreversed_s1");
   endtask

   task automatic test_settle_margin();
      run_a(0, 3, 0, 1'b1, "delay3");
      run_a(0, 5, 0, 1'b0, "delay5");
      dly = 0;
   endtask

   task automatic test_reset_mid_run();
      mode = 1; dly = 0;
      @(negedge UserCLK); start_a = 1'b1;
      @(posedge UserCLK); #1 start_a = 1'b0;
      repeat (200) @(negedge UserCLK);
      checks++;
      if (busy_a !== 1'b1 || err_a !== 8'd1) begin
         errors++;
         $display("FAIL mid_run_state: busy=%b err_count=%0d expected busy=1 err=1", busy_a, err_a);
      end
      Reset = 1'b1;
      @(posedge UserCLK);
      @(negedge UserCLK);
      check_all_zero("reset_mid_run");
      Reset = 1'b0;
      repeat (3) @(negedge UserCLK);
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || tx_word_a !== 28'h0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b tx=%h expected 0 0 0", busy_a, done_a, tx_word_a);
      end
      run_a(0, 0, 0, 1'b1, "rerun_after_reset");
   endtask

   task automatic test_saturation();
      result_t exp_r, r;
      int      n, busy_cnt, first_done, c;
      n = 28 + NR_B;
      exp_r.err = (n > 255) ? 8'd255 : 8'(n);
      exp_r.mask = {36{1'b1}};
      exp_r.pass = 1'b0;
      res_q.push_back(exp_r);
      @(negedge UserCLK); start_b = 1'b1;
      @(posedge UserCLK); #1 start_b = 1'b0;
      busy_cnt = 0; first_done = 0; c = 0;
      while (first_done == 0 && c < 2000) begin
         @(negedge UserCLK);
         c++;
         if (busy_b) busy_cnt++;
         if (done_b) first_done = c;
      end
      r = res_q.pop_front();
      checks++;
      if (first_done != n * (S_B + 1) + 1) begin
         errors++;
         $display("FAIL saturation done_cycle: got %0d expected %0d", first_done, n * (S_B + 1) + 1);
      end
      checks++;
      if (busy_cnt != n * (S_B + 1)) begin
         errors++;
         $display("FAIL saturation busy_cycles: got %0d expected %0d", busy_cnt, n * (S_B + 1));
      end
      checks++;
      if (err_b !== r.err) begin
         errors++;
         $display("FAIL saturation err_count: got %0d expected %0d", err_b, r.err);
      end
      checks++;
      if (mask_b !== r.mask) begin
         errors++;
         $display("FAIL saturation fail_mask: got %h expected %h", mask_b, r.mask);
      end
      checks++;
      if (pass_b !== r.pass) begin
         errors++;
         $display("FAIL saturation pass: got %b expected %b", pass_b, r.pass);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_start_ignored();
      test_stuck_s4();
      test_unreversed_s1();
      test_settle_margin();
      test_reset_mid_run();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
